// File: rtl/module_disp_scan.sv
// rtl/module_disp_scan.sv - multi-digit 7-segment scan controller with frame-aligned word load
module module_disp_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld,
  input  logic [4*N_DIGITS-1:0]   num,
  input  logic                    blank_lz,
  output logic                    ld_ack,
  output logic [3:0]              w,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*N_DIGITS-1:0]   r_shown;
  logic [4*N_DIGITS-1:0]   r_pend;
  logic                    r_pend_v;
  logic                    r_ld_ack;
  logic [3:0]              r_w;
  logic [N_DIGITS-1:0]     r_an;

  logic                    w_cnt_wrap;
  logic                    w_boundary;
  logic [3:0]              w_digit;
  logic [N_DIGITS-1:0]     w_an_sel;
  logic                    w_blank_sel;
  logic                    w_zero_run;

  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_boundary = w_cnt_wrap && (r_idx == IDX_LAST);

  // Prescaler and digit index: each digit dwells REFRESH_DIV cycles, index wraps per frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Loads park in pend until the frame boundary; a load on the boundary itself bypasses pend
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shown  <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_ld_ack <= 1'b0;
    end else begin
      r_ld_ack <= 1'b0;
      if (w_boundary) begin
        r_pend_v <= 1'b0;
        r_ld_ack <= ld || r_pend_v;
        if (ld) begin
          r_shown <= num;
        end else if (r_pend_v) begin
          r_shown <= r_pend;
        end
      end else if (ld) begin
        r_pend   <= num;
        r_pend_v <= 1'b1;
      end
    end
  end

  // Select the current digit, its anode, and whether it is a blanked leading zero
  always_comb begin
    w_digit     = 4'd0;
    w_an_sel    = '1;
    w_blank_sel = 1'b0;
    w_zero_run  = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_shown[4*k +: 4] == 4'd0);
      if (r_idx == IW'(k)) begin
        w_digit     = r_shown[4*k +: 4];
        w_an_sel[k] = 1'b0;
        w_blank_sel = blank_lz && w_zero_run && (k != 0);
      end
    end
  end

  // Register code and anode together so they always change on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w  <= 4'd0;
      r_an <= '1;
    end else if (w_blank_sel) begin
      r_w  <= 4'd0;
      r_an <= '1;
    end else begin
      r_w  <= w_digit;
      r_an <= w_an_sel;
    end
  end

  assign ld_ack = r_ld_ack;
  assign w      = r_w;
  assign an     = r_an;
  assign frame  = w_boundary;

endmodule
